// File: rtl/mem_stage_fwd_if.sv
// EX/MEM -> MEM/WB bus bundle for the MEM stage.
// Master drives the EX/MEM bus; slave returns MEM/WB and the forward flag.
interface mem_stage_fwd_if;
    logic [74:0] ex_mem;
    logic [70:0] mem_wb;
    logic        fwd_sel;

    modport master (
        output ex_mem,
        input  mem_wb,
        input  fwd_sel
    );

    modport slave (
        input  ex_mem,
        output mem_wb,
        output fwd_sel
    );
endinterface

// File: rtl/mem_stage_fwd.sv
// MEM stage: 1024x32 data memory, MEM/WB register, store-data forwarding.
// Forwarding unit is built only when MEM_STORE_FWD_EN is defined.
module mem_stage_fwd (
    input  logic           clk,
    input  logic           rst_n,
    mem_stage_fwd_if.slave bus
);
    logic [31:0] r_mem [0:1023];
    logic [70:0] r_mem_wb;

    logic [31:0] w_addr;
    logic [31:0] w_st_in;
    logic [31:0] w_rd_data;
    logic [31:0] w_store_data;
    logic [4:0]  w_dest;
    logic [9:0]  w_idx;
    logic        w_mem_read;
    logic        w_mem_to_reg;
    logic        w_mem_write;
    logic        w_reg_write;
    logic        w_fwd;
    logic        w_unused_ok;

    assign w_addr       = bus.ex_mem[31:0];
    assign w_st_in      = bus.ex_mem[63:32];
    assign w_dest       = bus.ex_mem[68:64];
    assign w_mem_read   = bus.ex_mem[71];
    assign w_mem_to_reg = bus.ex_mem[72];
    assign w_mem_write  = bus.ex_mem[73];
    assign w_reg_write  = bus.ex_mem[74];
    assign w_idx        = w_addr[9:0];
    assign w_unused_ok  = &{1'b0, bus.ex_mem[70:69]};

    assign w_rd_data = w_mem_read ? r_mem[w_idx] : 32'h0;

`ifdef MEM_STORE_FWD_EN
    // Load in MEM/WB feeds a store to the same (non-zero) register.
    assign w_fwd = r_mem_wb[37]
                 & r_mem_wb[70]
                 & w_mem_write
                 & (r_mem_wb[36:32] == w_dest)
                 & (w_dest != 5'd0);
    assign w_store_data = w_fwd ? r_mem_wb[31:0] : w_st_in;
`else
    assign w_fwd        = 1'b0;
    assign w_store_data = w_st_in;
`endif

    // Array is not reset; writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && w_mem_write)
            r_mem[w_idx] <= w_store_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_mem_wb <= '0;
        else
            r_mem_wb <= {w_mem_to_reg, w_addr, w_reg_write,
                         w_dest, w_rd_data};
    end

    assign bus.mem_wb  = r_mem_wb;
    assign bus.fwd_sel = w_fwd;
endmodule

// File: tb/tb_mem_stage_fwd.sv
// Directed bench for mem_stage_fwd with a MEM/WB scoreboard queue.
// Expectations follow MEM_STORE_FWD_EN when it is defined.
module tb_mem_stage_fwd;
    logic clk;
    logic rst_n;
    int   vecs;
    int   errs;

    logic [70:0] sb[$];

    mem_stage_fwd_if bus_if ();

    mem_stage_fwd dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

`ifdef MEM_STORE_FWD_EN
    localparam logic        FWD    = 1'b1;
    localparam logic [31:0] FWD_RD = 32'hDEADBEEF;
`else
    localparam logic        FWD    = 1'b0;
    localparam logic [31:0] FWD_RD = 32'h00001111;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [74:0] mk(
        input logic [31:0] addr,
        input logic [31:0] data,
        input logic [4:0]  dest,
        input logic        mr,
        input logic        m2r,
        input logic        mw,
        input logic        rw
    );
        return {rw, mw, m2r, mr, 2'b00, dest, data, addr};
    endfunction

    task automatic chk(input string tag, input logic [70:0] got,
                       input logic [70:0] want);
        vecs++;
        assert (got === want) else begin
            errs++;
            $error("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Drive one EX/MEM word, check fwd_sel, then check MEM/WB after the edge.
    task automatic cyc(input logic [74:0] ex, input logic [31:0] rd,
                       input logic f, input string tag);
        logic [70:0] e;
        bus_if.ex_mem = ex;
        #1;
        chk({tag, ".fwd"}, {70'h0, bus_if.fwd_sel}, {70'h0, f});
        sb.push_back({ex[72], ex[31:0], ex[74], ex[68:64], rd});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".wb"}, bus_if.mem_wb, e);
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        rst_n = 1'b1;
        bus_if.ex_mem = '0;
        @(posedge clk);
        #1;

        cyc(mk(32'h30, 32'h12345678, 5'd7, 1'b0, 1'b1, 1'b1, 1'b1),
            32'h0, 1'b0, "pre_sw");

        rst_n = 1'b0;
        bus_if.ex_mem = mk(32'h30, 32'hBADBAD00, 5'd8,
                           1'b1, 1'b1, 1'b1, 1'b1);
        bus_if.ex_mem[63:32] = $urandom;
        #1;
        chk("rst_async", bus_if.mem_wb, 71'h0);
        chk("rst_fwd", {70'h0, bus_if.fwd_sel}, 71'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold", bus_if.mem_wb, 71'h0);
        rst_n = 1'b1;

        cyc(mk(32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0),
            32'h0, 1'b0, "release");

        cyc(mk(32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0),
            32'h0, 1'b0, "sw10");
        cyc(mk(32'h10, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1),
            32'hDEADBEEF, 1'b0, "lw10");

        cyc(mk(32'h10, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1),
            32'hDEADBEEF, 1'b0, "lw_r8");
        cyc(mk(32'h20, 32'h1111, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0),
            32'h0, FWD, "sw_fwd");
        cyc(mk(32'h20, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1),
            FWD_RD, 1'b0, "lw20");

        cyc(mk(32'h10, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1),
            32'hDEADBEEF, 1'b0, "lw_r0");
        cyc(mk(32'h24, 32'h1111, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0),
            32'h0, 1'b0, "sw_r0");
        cyc(mk(32'h24, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1),
            32'h1111, 1'b0, "lw24");

        cyc(mk(32'h10, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0),
            32'hDEADBEEF, 1'b0, "lw_norw");
        cyc(mk(32'h28, 32'h1111, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0),
            32'h0, 1'b0, "sw_norw");
        cyc(mk(32'h28, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1),
            32'h1111, 1'b0, "lw28");

        cyc(mk(32'h10, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1),
            32'hDEADBEEF, 1'b0, "lw_r9");
        cyc(mk(32'h2C, 32'h1111, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0),
            32'h0, 1'b0, "sw_mis");
        cyc(mk(32'h2C, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1),
            32'h1111, 1'b0, "lw2c");

        cyc(mk(32'h10, 32'h0, 5'd4, 1'b0, 1'b1, 1'b0, 1'b1),
            32'h0, 1'b0, "rd_gate");
        cyc(mk(32'h01010411, 32'h01010101, 5'd0,
               1'b0, 1'b0, 1'b1, 1'b0),
            32'h0, 1'b0, "sw_alias");
        cyc(mk(32'h11, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1),
            32'h01010101, 1'b0, "lw_alias");

        cyc(mk(32'h30, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1),
            32'h12345678, 1'b0, "rst_keep");

        cyc(mk(32'h40, 32'hAAAA0000, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0),
            32'h0, 1'b0, "sw40");
        cyc(mk(32'h40, 32'h5555FFFF, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1),
            32'hAAAA0000, 1'b0, "rw40");
        cyc(mk(32'h40, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1),
            32'h5555FFFF, 1'b0, "lw40");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
